// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its queue.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    localparam int unsigned INST_BYTES = 4;
    localparam logic [31:0] NOP        = 32'h00000013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched words; flush wins over push/pop, and push+pop
// in the same cycle is allowed even when full.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned QDEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(QDEPTH+1)-1:0]  count
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    fetch_entry_t  mem_q [QDEPTH];
    fetch_entry_t  mem_d [QDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end else begin
                count_d = count_q;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the fetch PC, drives instruction memory, queues fetched
// words toward decode, and handles redirects, end-of-image drain and misalignment faults.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [63:0] PC_RESET  = 64'h0,
    parameter int unsigned MEM_BYTES = 112,
    parameter int unsigned QDEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [63:0] if_pc,
    output logic [1:0]  fetch_state
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);

    fetch_state_e  state_q, state_d;
    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic          q_push_s, q_pop_s, q_flush_s;
    logic          deq_s, enq_ok_s, past_end_s, if_valid_s;
    fetch_entry_t  q_head_s, q_push_data_s;
    logic [CW-1:0] q_count_s;

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push_s),
        .push_data (q_push_data_s),
        .pop       (q_pop_s),
        .flush     (q_flush_s),
        .head      (q_head_s),
        .count     (q_count_s)
    );

    assign if_valid_s    = (q_count_s != '0) && (state_q != ST_FAULT);
    assign deq_s         = if_valid_s && if_ready;
    assign q_pop_s       = deq_s;
    assign enq_ok_s      = (q_count_s < CW'(QDEPTH)) || deq_s;
    // 65-bit sum so a PC near 2^64 cannot wrap past the image bound.
    assign past_end_s    = ({1'b0, fetch_pc_q} + 65'(INST_BYTES)) > 65'(MEM_BYTES);
    assign q_push_data_s = '{pc: fetch_pc_q, inst: Instruction};

    // Next state, next PC and queue control; redirect outranks fetch.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        q_push_s   = 1'b0;
        q_flush_s  = 1'b0;
        case (state_q)
            ST_RUN, ST_DRAIN: begin
                if (redirect_valid) begin
                    q_flush_s = 1'b1;
                    if (redirect_pc[1:0] != 2'b00) begin
                        state_d = ST_FAULT;
                    end else begin
                        fetch_pc_d = redirect_pc;
                        state_d    = ST_RUN;
                    end
                end else if ((state_q == ST_RUN) && past_end_s) begin
                    state_d = ST_DRAIN;
                end else if ((state_q == ST_RUN) && enq_ok_s) begin
                    q_push_s   = 1'b1;
                    fetch_pc_d = fetch_pc_q + 64'(INST_BYTES);
                end else begin
                    state_d = state_q;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase
    end

    // State and fetch PC registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= PC_RESET;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign Inst_Address = fetch_pc_q;
    assign fetch_state  = state_q;
    assign if_valid     = if_valid_s;
    assign if_pc        = if_valid_s ? q_head_s.pc   : 64'd0;
    assign if_inst      = if_valid_s ? q_head_s.inst : 32'd0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios then random traffic,
// compared every cycle against a queue-based reference model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] Inst_Address;
    logic [31:0] Instruction;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [63:0] if_pc;
    logic [1:0]  fetch_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rom [0:27];

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc;
    int          m_st;   // 0 run, 1 drain, 2 fault

    fetch_sequencer #(.PC_RESET(64'h0), .MEM_BYTES(112), .QDEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .Inst_Address   (Inst_Address),
        .Instruction    (Instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .fetch_state    (fetch_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a < 64'd112) return rom[a[6:2]];
        return 32'h00000013;
    endfunction

    always_comb Instruction = mem_word(Inst_Address);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour at one rising edge, from the inputs held across it.
    task automatic model_upd();
        logic        deq;
        logic [64:0] nxt;
        if (reset) begin
            mq.delete();
            m_pc = 64'h0;
            m_st = 0;
        end else if (m_st != 2) begin
            deq = (mq.size() > 0) && if_ready;
            if (deq) void'(mq.pop_front());
            nxt = {1'b0, m_pc} + 65'd4;
            if (redirect_valid) begin
                mq.delete();
                if (redirect_pc[1:0] != 2'b00) m_st = 2;
                else begin
                    m_pc = redirect_pc;
                    m_st = 0;
                end
            end else if (m_st == 0) begin
                if (nxt > 65'd112) m_st = 1;
                else if (mq.size() < 2) begin
                    mq.push_back('{pc: m_pc, inst: mem_word(m_pc)});
                    m_pc = m_pc + 64'd4;
                end
            end
        end
    endtask

    task automatic model_chk();
        logic        v;
        logic [63:0] p;
        logic [31:0] w;
        v = (mq.size() > 0);
        p = v ? mq[0].pc : 64'd0;
        w = v ? mq[0].inst : 32'd0;
        chk("if_valid", {63'd0, if_valid}, {63'd0, v});
        chk("if_pc", if_pc, p);
        chk("if_inst", {32'd0, if_inst}, {32'd0, w});
        chk("inst_address", Inst_Address, m_pc);
        chk("fetch_state", {62'd0, fetch_state}, 64'(m_st));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_upd();
        #1;
        model_chk();
    endtask

    initial begin
        logic [63:0] last_pc;
        int          r;
        for (int i = 0; i < 28; i++) rom[i] = $urandom;
        rom[0]  = 32'h00700993;
        rom[1]  = 32'h07340663;
        rom[16] = 32'hfc000ce3;
        m_pc = 64'h0;
        m_st = 0;

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0; if_ready = 1'b0;
        @(posedge clk); #1;
        cyc();
        chk("rst_valid", {63'd0, if_valid}, 64'd0);
        chk("rst_addr", Inst_Address, 64'd0);
        chk("rst_pc", if_pc, 64'd0);

        // Streaming from reset with decode always ready.
        reset = 1'b0; if_ready = 1'b1;
        cyc(); chk("stream_pc0", if_pc, 64'd0); chk("stream_inst0", {32'd0, if_inst}, 64'h00700993);
        cyc(); chk("stream_pc4", if_pc, 64'd4); chk("stream_inst4", {32'd0, if_inst}, 64'h07340663);
        cyc(); chk("stream_pc8", if_pc, 64'd8); chk("stream_valid8", {63'd0, if_valid}, 64'd1);

        // Back-pressure fills the queue.
        reset = 1'b1; cyc();
        reset = 1'b0; if_ready = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        chk("full_addr", Inst_Address, 64'd8);
        chk("full_head", if_pc, 64'd0);
        if_ready = 1'b1;
        cyc(); chk("release_pc4", if_pc, 64'd4);
        cyc(); chk("release_pc8", if_pc, 64'd8);

        // Redirect while pc 8/12 are queued and not accepted.
        if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h40;
        cyc();
        chk("redir_bubble", {63'd0, if_valid}, 64'd0);
        chk("redir_addr", Inst_Address, 64'h40);
        redirect_valid = 1'b0; if_ready = 1'b1;
        cyc();
        chk("redir_pc", if_pc, 64'h40);
        chk("redir_inst", {32'd0, if_inst}, 64'hfc000ce3);

        // Stream to end of image.
        last_pc = 64'h0;
        for (int i = 0; i < 60 && !(m_st == 1 && mq.size() == 0); i++) begin
            if (if_valid) last_pc = if_pc;
            cyc();
        end
        chk("drain_state", {62'd0, fetch_state}, 64'd1);
        chk("drain_last_pc", last_pc, 64'd108);
        cyc(); cyc();
        chk("drain_idle", {63'd0, if_valid}, 64'd0);
        redirect_valid = 1'b1; redirect_pc = 64'h10;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        chk("drain_exit_state", {62'd0, fetch_state}, 64'd0);
        chk("drain_exit_pc", if_pc, 64'h10);

        // Misaligned redirect faults; aligned redirect afterwards is ignored.
        redirect_valid = 1'b1; redirect_pc = 64'h42;
        cyc();
        chk("fault_state", {62'd0, fetch_state}, 64'd2);
        chk("fault_valid", {63'd0, if_valid}, 64'd0);
        redirect_pc = 64'h20;
        cyc();
        chk("fault_sticky", {62'd0, fetch_state}, 64'd2);
        redirect_valid = 1'b0; reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        chk("fault_recover_state", {62'd0, fetch_state}, 64'd0);
        chk("fault_recover_pc", if_pc, 64'd0);

        // Reset with a full queue and a concurrent redirect.
        if_ready = 1'b0;
        cyc(); cyc(); cyc();
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h30;
        cyc();
        chk("rst_redir_valid", {63'd0, if_valid}, 64'd0);
        chk("rst_redir_addr", Inst_Address, 64'd0);
        reset = 1'b0; redirect_valid = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 39) == 0);
            if_ready       = $urandom_range(0, 2) != 0;
            redirect_valid = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 7);
            if (r == 0)      redirect_pc = 64'(($urandom_range(0, 27) * 4) + $urandom_range(1, 3));
            else if (r == 1) redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
            else if (r == 2) redirect_pc = 64'd108;
            else             redirect_pc = 64'($urandom_range(0, 27) * 4);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
